// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - FSM state encodings, legal byte-lane patterns and timing defaults for dmem_resp
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmemState;

    localparam int WAIT_CYCLES_DEFAULT = 1;

    localparam logic [3:0] AMP_BYTE0 = 4'b0001;
    localparam logic [3:0] AMP_BYTE1 = 4'b0010;
    localparam logic [3:0] AMP_BYTE2 = 4'b0100;
    localparam logic [3:0] AMP_BYTE3 = 4'b1000;
    localparam logic [3:0] AMP_HALF0 = 4'b0011;
    localparam logic [3:0] AMP_HALF1 = 4'b1100;
    localparam logic [3:0] AMP_WORD  = 4'b1111;

    function automatic logic ampLegal(input logic [3:0] amp);
        case (amp)
            AMP_BYTE0, AMP_BYTE1, AMP_BYTE2, AMP_BYTE3,
            AMP_HALF0, AMP_HALF1, AMP_WORD: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - request/response bus between a load/store requester and dmem_resp
interface dmem_resp_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  amp;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req_valid, addr, wdata, we, amp,
        input  req_ready, rsp_valid, rdata, err
    );

    modport slave (
        input  req_valid, addr, wdata, we, amp,
        output req_ready, rsp_valid, rdata, err
    );

endinterface

// File: rtl/dmem_resp_ram.sv
// rtl/dmem_resp_ram.sv - dmem_ram: word array with one synchronous read/write port and byte write enables
module dmem_ram #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    byteEn,
    input  logic [AW-1:0] index,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[index][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // Read register doubles as the response data holder, so it only moves on loads.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dout <= '0;
        end else if (en && !we) begin
            dout <= mem[index];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - data memory responder: accept/wait/respond FSM around dmem_ram
// Optional byte-lane pattern checking with err reporting: DMEM_MISALIGN_CHK_EN
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    dmem_resp_if.slave bus
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmemState      state;
    logic [3:0]    cnt;
    logic          reqReady;
    logic          rspValid;
    logic          capWe;
    logic [AW-1:0] capIndex;
    logic [31:0]   capWdata;
    logic [3:0]    capAmp;

    logic          enterResp;
    logic          accWe;
    logic [AW-1:0] accIndex;
    logic [31:0]   accWdata;
    logic [3:0]    accAmp;
    logic          accIllegal;
    logic          ramEn;
    logic [3:0]    ramByteEn;
    logic [31:0]   ramDout;
    logic          unusedAddrBits;

    assign unusedAddrBits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

    // With zero wait states the memory is accessed on the accept edge itself,
    // so the live request must feed the RAM instead of the capture registers.
    assign enterResp = ((state == IDLE) && bus.req_valid && (WAIT_CYCLES == 0))
                     || ((state == WAIT) && (cnt == 4'd0));
    assign accWe     = (state == IDLE) ? bus.we              : capWe;
    assign accIndex  = (state == IDLE) ? bus.addr[AW+1:2]    : capIndex;
    assign accWdata  = (state == IDLE) ? bus.wdata           : capWdata;
    assign accAmp    = (state == IDLE) ? bus.amp             : capAmp;

    assign ramEn     = enterResp && reset;
    assign ramByteEn = accIllegal ? 4'b0000 : accAmp;

`ifdef DMEM_MISALIGN_CHK_EN
    logic errQ;

    assign accIllegal = !ampLegal(accAmp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            errQ <= 1'b0;
        end else begin
            errQ <= enterResp && accIllegal;
        end
    end

    assign bus.err = errQ;
`else
    assign accIllegal = 1'b0;
    assign bus.err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            reqReady <= 1'b1;
            rspValid <= 1'b0;
            capWe    <= 1'b0;
            capIndex <= '0;
            capWdata <= '0;
            capAmp   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        capWe    <= bus.we;
                        capIndex <= bus.addr[AW+1:2];
                        capWdata <= bus.wdata;
                        capAmp   <= bus.amp;
                        reqReady <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state    <= RESP;
                            rspValid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= RESP;
                        rspValid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    rspValid <= 1'b0;
                    reqReady <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    rspValid <= 1'b0;
                    reqReady <= 1'b1;
                end
            endcase
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .rstN  (reset),
        .en    (ramEn),
        .we    (accWe),
        .byteEn(ramByteEn),
        .index (accIndex),
        .din   (accWdata),
        .dout  (ramDout)
    );

    assign bus.req_ready = reqReady;
    assign bus.rsp_valid = rspValid;
    assign bus.rdata     = ramDout;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - randomized self-checking bench for dmem_resp against a word-array reference model
module tb_dmem_resp;

    localparam int W      = 1;
    localparam int DEPTH  = 1024;
    localparam int DEPTH0 = 16;
    localparam int NOPS0  = 60;
`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_resp_if bus ();
    dmem_resp_if bus0 ();

    dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    dmem_resp #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );

    int checks = 0;
    int passes = 0;
    logic [31:0] refMem [DEPTH];
    logic [31:0] refMem0 [DEPTH0];
    logic [31:0] lastRd  = '0;
    logic [31:0] lastRd0 = '0;

    function automatic bit ampIllegal(input logic [3:0] m);
        return CHK && !(m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    endfunction

    function automatic void refAccess(input logic w, input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] m, output logic [31:0] expRd, output logic expErr);
        int idx;
        idx    = int'((a / 4) % DEPTH);
        expErr = ampIllegal(m);
        if (w) begin
            if (!expErr) begin
                for (int i = 0; i < 4; i++) if (m[i]) refMem[idx][8*i +: 8] = d[8*i +: 8];
            end
            expRd = lastRd;
        end else begin
            expRd  = refMem[idx];
            lastRd = expRd;
        end
    endfunction

    task automatic doAccess(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            output logic [31:0] rd, output logic e, output int lat, output logic single);
        int guard = 0;
        @(negedge clk);
        bus.we = w; bus.addr = a; bus.wdata = d; bus.amp = m; bus.req_valid = 1'b1;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.we = 1'($urandom); bus.addr = $urandom; bus.wdata = $urandom; bus.amp = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 40);
        rd = bus.rdata;
        e  = bus.err;
        @(negedge clk);
        single = (bus.rsp_valid === 1'b0);
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.amp = '0;
        bus0.req_valid = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.amp = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); else passes++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else passes++;
        checks++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", bus.rdata); else passes++;
        checks++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else passes++;
        checks++; if (bus0.req_ready !== 1'b1) $display("FAIL reset_req_ready0: got %b want 1", bus0.req_ready); else passes++;
        reset   = 1'b1;
        lastRd  = '0;
        lastRd0 = '0;
    endtask

    task automatic test_fill();
        logic [31:0] rd, expRd, d;
        logic e, one, expErr;
        int lat;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            doAccess(1'b1, 32'(i * 4), d, 4'hF, rd, e, lat, one);
            refAccess(1'b1, 32'(i * 4), d, 4'hF, expRd, expErr);
            checks++;
            if (lat != W + 1 || !one) $display("FAIL fill_latency word=%0d: got lat=%0d single=%b want lat=%0d single=1", i, lat, one, W + 1);
            else passes++;
            checks++;
            if (rd !== expRd || e !== expErr) $display("FAIL fill_rsp word=%0d: got rdata=%h err=%b want %h/%b", i, rd, e, expRd, expErr);
            else passes++;
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, expRd;
        logic e, one, expErr;
        int lat;
        doAccess(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat, one);
        refAccess(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, expRd, expErr);
        checks++; if (lat != 2 || !one) $display("FAIL store_latency: got %0d single=%b want 2 single=1", lat, one); else passes++;
        doAccess(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat, one);
        refAccess(1'b0, 32'h10, 32'h0, 4'hF, expRd, expErr);
        checks++; if (lat != 2 || !one) $display("FAIL load_latency: got %0d single=%b want 2 single=1", lat, one); else passes++;
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL load_full_word: got %h want deadbeef", rd); else passes++;

        doAccess(1'b1, 32'h20, 32'h11223344, 4'hF, rd, e, lat, one);
        refAccess(1'b1, 32'h20, 32'h11223344, 4'hF, expRd, expErr);
        doAccess(1'b1, 32'h20, 32'h0000AA00, 4'b0010, rd, e, lat, one);
        refAccess(1'b1, 32'h20, 32'h0000AA00, 4'b0010, expRd, expErr);
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL store_keeps_rdata: got %h want deadbeef", rd); else passes++;
        doAccess(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat, one);
        refAccess(1'b0, 32'h20, 32'h0, 4'h0, expRd, expErr);
        checks++; if (rd !== 32'h1122AA44) $display("FAIL byte_lane_merge: got %h want 1122aa44", rd); else passes++;

        doAccess(1'b1, 32'h0, 32'h00000055, 4'b0001, rd, e, lat, one);
        refAccess(1'b1, 32'h0, 32'h00000055, 4'b0001, expRd, expErr);
        doAccess(1'b0, 32'h1000, 32'h0, 4'hF, rd, e, lat, one);
        refAccess(1'b0, 32'h1000, 32'h0, 4'hF, expRd, expErr);
        checks++; if (rd[7:0] !== 8'h55 || rd !== expRd) $display("FAIL addr_wrap: got %h want %h (low byte 55)", rd, expRd); else passes++;

        doAccess(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, rd, e, lat, one);
        refAccess(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, expRd, expErr);
        doAccess(1'b1, 32'h30, 32'h0, 4'b0000, rd, e, lat, one);
        refAccess(1'b1, 32'h30, 32'h0, 4'b0000, expRd, expErr);
        checks++; if (e !== CHK) $display("FAIL amp_zero_err: got %b want %b", e, CHK); else passes++;
        doAccess(1'b0, 32'h30, 32'h0, 4'hF, rd, e, lat, one);
        refAccess(1'b0, 32'h30, 32'h0, 4'hF, expRd, expErr);
        checks++; if (rd !== 32'hCAFEF00D) $display("FAIL amp_zero_nowrite: got %h want cafef00d", rd); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] rd, expRd, a, d;
        logic [3:0] m;
        logic w, e, one, expErr;
        int lat;
        for (int n = 0; n < 400; n++) begin
            w = 1'($urandom); a = $urandom; d = $urandom; m = 4'($urandom);
            doAccess(w, a, d, m, rd, e, lat, one);
            refAccess(w, a, d, m, expRd, expErr);
            checks++;
            if (lat != W + 1 || !one) $display("FAIL rand_latency n=%0d: got %0d single=%b want %0d single=1", n, lat, one, W + 1);
            else passes++;
            checks++;
            if (rd !== expRd || e !== expErr)
                $display("FAIL rand_rsp n=%0d we=%b addr=%h amp=%b: got rdata=%h err=%b want %h/%b", n, w, a, m, rd, e, expRd, expErr);
            else passes++;
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd, expRd;
        logic e, one, expErr;
        int lat;
        doAccess(1'b1, 32'h40, 32'h0, 4'hF, rd, e, lat, one);
        refAccess(1'b1, 32'h40, 32'h0, 4'hF, expRd, expErr);
        @(negedge clk);
        bus.we = 1'b1; bus.addr = 32'h40; bus.wdata = 32'hFFFFFFFF; bus.amp = 4'hF; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_wait_req_ready: got %b want 1", bus.req_ready); else passes++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_wait_rsp_valid: got %b want 0", bus.rsp_valid); else passes++;
        checks++; if (bus.rdata !== 32'h0 || bus.err !== 1'b0) $display("FAIL rst_wait_data: got %h/%b want 00000000/0", bus.rdata, bus.err); else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        lastRd = '0; lastRd0 = '0;
        doAccess(1'b0, 32'h40, 32'h0, 4'hF, rd, e, lat, one);
        refAccess(1'b0, 32'h40, 32'h0, 4'hF, expRd, expErr);
        checks++; if (rd !== 32'h0) $display("FAIL rst_wait_dropped_store: got %h want 00000000", rd); else passes++;

        @(negedge clk);
        bus.we = 1'b0; bus.addr = 32'h10; bus.amp = 4'hF; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL rst_resp_pre: got %b want 1", bus.rsp_valid); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rdata !== 32'h0) $display("FAIL rst_resp_drop: got %b/%h want 0/00000000", bus.rsp_valid, bus.rdata); else passes++;
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        lastRd = '0; lastRd0 = '0;
    endtask

    task automatic test_misalign();
        logic [31:0] rd, expRd, wantRd;
        logic e, one, expErr, wantErr;
        int lat;
`ifdef DMEM_MISALIGN_CHK_EN
        wantErr = 1'b1; wantRd = 32'h12345678;
`else
        wantErr = 1'b0; wantRd = 32'h12FFFF78;
`endif
        doAccess(1'b1, 32'h80, 32'h12345678, 4'hF, rd, e, lat, one);
        refAccess(1'b1, 32'h80, 32'h12345678, 4'hF, expRd, expErr);
        doAccess(1'b1, 32'h80, 32'hFFFFFFFF, 4'b0110, rd, e, lat, one);
        refAccess(1'b1, 32'h80, 32'hFFFFFFFF, 4'b0110, expRd, expErr);
        checks++; if (e !== wantErr || lat != W + 1) $display("FAIL misalign_store_err: got err=%b lat=%0d want %b/%0d", e, lat, wantErr, W + 1); else passes++;
        doAccess(1'b0, 32'h80, 32'h0, 4'b0101, rd, e, lat, one);
        refAccess(1'b0, 32'h80, 32'h0, 4'b0101, expRd, expErr);
        checks++; if (rd !== wantRd) $display("FAIL misalign_load_data: got %h want %h", rd, wantRd); else passes++;
        checks++; if (e !== wantErr) $display("FAIL misalign_load_err: got %b want %b", e, wantErr); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] qRd[$];
        logic qErr[$];
        logic [31:0] a, d, er;
        logic [3:0] m;
        logic w, ill;
        int idx;
        int k = 0;
        @(negedge clk);
        for (int j = 0; j <= 2 * NOPS0; j++) begin
            checks++;
            if (bus0.rsp_valid !== 1'(j % 2) || bus0.req_ready !== 1'((j + 1) % 2))
                $display("FAIL b2b_handshake cycle=%0d: got rsp_valid=%b req_ready=%b want %0d/%0d",
                         j, bus0.rsp_valid, bus0.req_ready, j % 2, (j + 1) % 2);
            else passes++;
            if (bus0.rsp_valid === 1'b1) begin
                checks++;
                if (qRd.size() == 0) begin
                    $display("FAIL b2b_extra_rsp cycle=%0d: got a response want none pending", j);
                end else begin
                    er  = qRd.pop_front();
                    ill = qErr.pop_front();
                    if (bus0.rdata !== er || bus0.err !== ill)
                        $display("FAIL b2b_rsp cycle=%0d: got rdata=%h err=%b want %h/%b", j, bus0.rdata, bus0.err, er, ill);
                    else passes++;
                end
            end
            if (bus0.req_ready === 1'b1 && k < NOPS0) begin
                if (k < DEPTH0) begin
                    w = 1'b1; a = 32'(k * 4); d = $urandom; m = 4'hF;
                end else begin
                    w = 1'($urandom); a = $urandom; d = $urandom; m = 4'($urandom);
                end
                idx = int'((a / 4) % DEPTH0);
                ill = ampIllegal(m);
                if (w) begin
                    if (!ill) for (int i = 0; i < 4; i++) if (m[i]) refMem0[idx][8*i +: 8] = d[8*i +: 8];
                end else begin
                    lastRd0 = refMem0[idx];
                end
                qRd.push_back(lastRd0);
                qErr.push_back(ill);
                bus0.we = w; bus0.addr = a; bus0.wdata = d; bus0.amp = m; bus0.req_valid = 1'b1;
                k++;
            end else if (bus0.req_ready === 1'b1) begin
                bus0.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (qRd.size() != 0 || k != NOPS0) $display("FAIL b2b_pending: got %0d unanswered of %0d issued want 0 of %0d", qRd.size(), k, NOPS0);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_random();
        test_reset_wait();
        test_misalign();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion within 2 ms want completion");
        $fatal(1);
    end

endmodule
